packet_gen: RTL
===============

Name: packet_gen

Overview:
- AXI-Stream packet transmitter that produces whole, well-formed test packets for the capture path. It is the upstream source for the input side of the capture gate.
- Emits N packets (or runs until stopped) of a programmed byte length, with a programmed idle gap between packets.
- Never emits a partial packet. A stop request takes effect only at a packet boundary.

Parameters:
- DW, 512, data bus width in bits; a multiple of 32. BPB = DW/8 bytes per beat.
- LEN_W, 16, width of the packet-length field (bytes).
- CNT_W, 32, width of the packet-count field and the sent counter.
- GAP_W, 16, width of the inter-packet gap field (clock cycles).

Ports:
- clk, in, 1, clock.
- reset, in, 1, reset: synchronous, active-high.
- start, in, 1, single-cycle pulse; begins a run when idle.
- stop, in, 1, single-cycle pulse; graceful stop at the next packet boundary.
- cfg_len, in, LEN_W, packet length in bytes; sampled on an accepted start.
- cfg_count, in, CNT_W, packets per run; 0 means unlimited.
- cfg_gap, in, GAP_W, idle cycles between packets.
- AXIS_OUT_TDATA, out, DW, packet data.
- AXIS_OUT_TKEEP, out, DW/8, byte enables.
- AXIS_OUT_TLAST, out, 1, last beat of the packet.
- AXIS_OUT_TVALID, out, 1, beat valid.
- AXIS_OUT_TREADY, in, 1, downstream ready.
- busy, out, 1, high whenever the state is not IDLE.
- packets_sent, out, CNT_W, packets completed in the current or last run.

Behaviour:
- Reset values: state = IDLE. TVALID, TLAST, TKEEP, TDATA, busy, packets_sent, stop_pending and all counters are 0.
- All outputs are registered.
- Handshake = TVALID & TREADY.
- Beats per packet: last_beat = ceil(cfg_len/BPB) - 1, computed on start and held for the whole run.
- TKEEP:
  - all ones on every non-last beat;
  - on the last beat, the low (cfg_len mod BPB) bits are set;
  - if the remainder is 0, all bits are set.
- TDATA: every 32-bit lane of a beat carries seq.
  - seq is a 32-bit beat counter, cleared on start, incremented on each handshake, wrapping modulo 2^32.
  - Lanes above the TKEEP boundary also carry seq; their content is don't-care for checkers.
- TLAST = 1 exactly when the beat index equals last_beat.
- AXIS rule: once TVALID is 1, TDATA, TKEEP and TLAST are held stable and TVALID stays 1 until the handshake.
- State IDLE:
  - Outputs: TVALID = 0, busy = 0.
  - Trigger: start with cfg_len != 0.
  - Action: latch the config; clear packets_sent, seq, the beat index and stop_pending.
  - Next state: SEND. TVALID rises the next cycle, so latency start -> first TVALID is 1 cycle.
  - start with cfg_len = 0 is ignored; stop in IDLE is ignored.
- State SEND:
  - TVALID = 1.
  - Each handshake advances the beat index.
  - On the TLAST handshake, packets_sent increments and the beat index resets to 0, then the first matching rule applies:
    - (cfg_count != 0 and packets_sent+1 == cfg_count) or stop_pending -> IDLE, with TVALID = 0 on the next cycle;
    - cfg_gap == 0 -> stay in SEND; the next packet's first beat is presented on the next cycle (back-to-back);
    - otherwise -> GAP, with the gap counter loaded with cfg_gap.
- State GAP:
  - TVALID = 0; the gap counter decrements each cycle.
  - At 1 the next state is SEND, giving exactly cfg_gap idle cycles.
  - If stop_pending is set, the next state is IDLE immediately.
- stop while busy sets stop_pending. stop_pending is cleared on entry to IDLE.
- A stop in the same cycle as the TLAST handshake counts as pending and ends the run after that packet.
- start while busy is ignored. Changes to cfg_* while busy have no effect.
- Simultaneous start and stop in IDLE: the start is accepted and the stop is discarded.
- TREADY held low stalls the beat indefinitely with its data frozen. The gap counter only runs in GAP.
- Reset mid-packet: everything returns to the reset values on the next edge, and TVALID drops at once. This truncation is the only permitted one.
- packets_sent holds its final value in IDLE until the next accepted start.

Decomposition:
- Package packet_gen_pkg holds:
  - the state enum (IDLE, SEND, GAP);
  - the BPB localparam;
  - a function keep_mask(len_mod, BPB) returning the last-beat TKEEP.
- No sub-module; the FSM, counters and output register fit in one module.

Test Plan:
- Exact-multiple length: DW = 512, cfg_len = 128, cfg_count = 2, cfg_gap = 0, TREADY = 1 -> 4 beats back-to-back; TLAST on beats 1 and 3; TKEEP all ones; seq = 0..3; packets_sent = 2; busy falls.
- Partial last beat: cfg_len = 65, count = 1 -> 2 beats; last-beat TKEEP = 64'h1; TLAST only on beat 2.
- Gap with backpressure: cfg_len = 64, count = 3, gap = 5, random TREADY -> each packet is 1 beat; exactly 5 TVALID-low cycles between packets; data stable while stalled; no beat lost or duplicated.
- Graceful stop: count = 0, cfg_len = 256, stop pulsed on beat 2 of packet 3 -> packet 3 completes (4 beats); then IDLE; packets_sent = 3.
- Stop timing: stop during GAP -> IDLE the next cycle with no further TVALID. start while busy is ignored; start with cfg_len = 0 in IDLE leaves busy = 0.
- Reset mid-packet on beat 1 -> TVALID, busy and packets_sent are 0 after the edge; a new start afterwards begins with seq = 0.

Source files
------------

// File: rtl/packet_gen_pkg.sv
// Shared types and helpers for the AXI-Stream test-packet generator.
// Holds the FSM state encoding, the default bytes-per-beat and the
// last-beat byte-enable helper used when a run is configured.
package packet_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_DW = 512;
  localparam int unsigned BPB        = DEFAULT_DW / 8;

  // Widest beat the helper can describe; callers cast down to their own width.
  localparam int unsigned MAX_BPB = 128;

  // Byte enables for the last beat of a packet: the low len_mod bytes,
  // or the whole beat when the length is an exact multiple of the beat size.
  function automatic logic [MAX_BPB-1:0] keep_mask(input int unsigned len_mod,
                                                   input int unsigned bpb);
    logic [MAX_BPB-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BPB; i++) begin
      m[i] = (len_mod == 0) ? (i < bpb) : (i < len_mod);
    end
    return m;
  endfunction

endpackage

// File: rtl/packet_gen.sv
// AXI-Stream generator of whole test packets: N packets (0 = until stopped) of cfg_len bytes, cfg_gap idle cycles apart.
// Latency: first TVALID one cycle after an accepted start; back-to-back packets when cfg_gap is 0.
// Backpressure: TREADY low freezes the presented beat; stop only takes effect at a packet boundary.
//
// Ports: clk, reset (sync, active-high); start/stop pulses; cfg_len/cfg_count/cfg_gap
// sampled on an accepted start; AXIS_OUT_* master stream; busy and packets_sent status.
module packet_gen
  import packet_gen_pkg::*;
#(
  parameter int unsigned DW    = 512,
  parameter int unsigned LEN_W = 16,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned GAP_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [GAP_W-1:0] cfg_gap,
  output logic [DW-1:0]    AXIS_OUT_TDATA,
  output logic [DW/8-1:0]  AXIS_OUT_TKEEP,
  output logic             AXIS_OUT_TLAST,
  output logic             AXIS_OUT_TVALID,
  input  logic             AXIS_OUT_TREADY,
  output logic             busy,
  output logic [CNT_W-1:0] packets_sent
);

  localparam int unsigned NB = DW / 8;   // bytes per beat
  localparam int unsigned NL = DW / 32;  // 32-bit lanes per beat

  state_t           r_state;
  logic [LEN_W-1:0] r_last_beat, r_beat;
  logic [CNT_W-1:0] r_count, r_sent;
  logic [GAP_W-1:0] r_gap, r_gap_cnt;
  logic [NB-1:0]    r_keep_last, r_tkeep;
  logic [31:0]      r_seq;
  logic [DW-1:0]    r_tdata;
  logic             r_stop_pending, r_tvalid, r_tlast, r_busy;

  logic             w_hs, w_is_last, w_stop_pend, w_done, w_first_last;
  logic [31:0]      w_seq_nxt, w_nbeats;
  logic [CNT_W-1:0] w_sent_nxt;
  logic [LEN_W-1:0] w_beat_nxt, w_start_last;
  logic [NB-1:0]    w_start_keep, w_first_keep;

  assign w_hs        = r_tvalid & AXIS_OUT_TREADY;
  assign w_is_last   = (r_beat == r_last_beat);
  assign w_seq_nxt   = r_seq + 32'd1;
  assign w_sent_nxt  = r_sent + CNT_W'(1);
  assign w_beat_nxt  = r_beat + LEN_W'(1);
  // A stop arriving in the same cycle as the TLAST handshake still ends the run.
  assign w_stop_pend = r_stop_pending | stop;
  assign w_done      = ((r_count != '0) && (w_sent_nxt == r_count)) || w_stop_pend;

  // Run configuration derived from the live cfg inputs at start time.
  assign w_nbeats     = (32'(cfg_len) + NB - 32'd1) / NB;
  assign w_start_last = LEN_W'(w_nbeats - 32'd1);
  assign w_start_keep = NB'(keep_mask(32'(cfg_len) % NB, NB));

  // First beat of a later packet in the same run (single-beat packets are also last).
  assign w_first_last = (r_last_beat == '0);
  assign w_first_keep = w_first_last ? r_keep_last : '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_last_beat    <= '0;
      r_beat         <= '0;
      r_count        <= '0;
      r_sent         <= '0;
      r_gap          <= '0;
      r_gap_cnt      <= '0;
      r_keep_last    <= '0;
      r_tkeep        <= '0;
      r_seq          <= '0;
      r_tdata        <= '0;
      r_stop_pending <= 1'b0;
      r_tvalid       <= 1'b0;
      r_tlast        <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // A concurrent stop is dropped: stop_pending is cleared here.
          if (start && (cfg_len != '0)) begin
            r_state        <= SEND;
            r_busy         <= 1'b1;
            r_tvalid       <= 1'b1;
            r_last_beat    <= w_start_last;
            r_count        <= cfg_count;
            r_gap          <= cfg_gap;
            r_keep_last    <= w_start_keep;
            r_sent         <= '0;
            r_seq          <= '0;
            r_beat         <= '0;
            r_gap_cnt      <= '0;
            r_stop_pending <= 1'b0;
            r_tdata        <= '0;
            r_tlast        <= (w_start_last == '0);
            r_tkeep        <= (w_start_last == '0) ? w_start_keep : '1;
          end
        end

        SEND: begin
          r_stop_pending <= w_stop_pend;
          if (w_hs) begin
            r_seq <= w_seq_nxt;
            if (!w_is_last) begin
              r_beat  <= w_beat_nxt;
              r_tdata <= {NL{w_seq_nxt}};
              r_tlast <= (w_beat_nxt == r_last_beat);
              r_tkeep <= (w_beat_nxt == r_last_beat) ? r_keep_last : '1;
            end else begin
              r_sent <= w_sent_nxt;
              r_beat <= '0;
              if (w_done) begin
                r_state        <= IDLE;
                r_busy         <= 1'b0;
                r_tvalid       <= 1'b0;
                r_tlast        <= 1'b0;
                r_stop_pending <= 1'b0;
              end else if (r_gap == '0) begin
                r_tdata <= {NL{w_seq_nxt}};
                r_tlast <= w_first_last;
                r_tkeep <= w_first_keep;
              end else begin
                r_state   <= GAP;
                r_tvalid  <= 1'b0;
                r_tlast   <= 1'b0;
                r_gap_cnt <= r_gap;
              end
            end
          end
        end

        GAP: begin
          if (w_stop_pend) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_stop_pending <= 1'b0;
            r_gap_cnt      <= '0;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            // Leaving at a count of 1 yields exactly cfg_gap idle cycles.
            if (r_gap_cnt == GAP_W'(1)) begin
              r_state  <= SEND;
              r_tvalid <= 1'b1;
              r_tdata  <= {NL{r_seq}};
              r_tlast  <= w_first_last;
              r_tkeep  <= w_first_keep;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign AXIS_OUT_TDATA  = r_tdata;
  assign AXIS_OUT_TKEEP  = r_tkeep;
  assign AXIS_OUT_TLAST  = r_tlast;
  assign AXIS_OUT_TVALID = r_tvalid;
  assign busy            = r_busy;
  assign packets_sent    = r_sent;

endmodule
